// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store initiator between the CPU memory stage and a word-only
// data memory; SB/SH are done as read-modify-write over two memory cycles.
// Ports: req_* (valid/ready request in), rsp_* (valid/ready response out),
//        mem_ce/mem_we/mem_addr/mem_wtData/mem_rdData (word memory side).
// Option: define LSU_ERR_EN to flag misaligned or out-of-range (>= MEM_BYTES)
//         accesses; otherwise rsp_err is 0 and addresses are truncated.
module lsu_mem_if #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wtData,
  input  logic [31:0] mem_rdData
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {
    IDLE, ACCESS, RMW_RD, RMW_WR, RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        req_err;

`ifdef LSU_ERR_EN
  logic misal;
  always_comb begin
    misal = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         misal = |req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: misal = req_addr[0];
      default:              misal = 1'b0;
    endcase
    req_err = misal || (req_addr >= MEM_BYTES);
  end
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_BYTES == 0);
  assign req_err = 1'b0;
`endif

  // Little-endian lane pick; halfwords look at lane[1] only.
  function automatic logic [31:0] load_ext(
    input logic [2:0]  op,
    input logic [1:0]  lane,
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0, h};
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h0, b};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [2:0]  op,
    input logic [1:0]  lane,
    input logic [31:0] old,
    input logic [31:0] wd
  );
    merge = old;
    if (op == OP_SB)
      merge[{lane, 3'b000} +: 8] = wd[7:0];
    else if (lane[1])
      merge[31:16] = wd[15:0];
    else
      merge[15:0] = wd[15:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    old_d      = old_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wtData = 32'h0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d       = req_op;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rsp_data_d = 32'h0;
          rsp_err_d  = req_err;
          if (req_err)
            state_d = RESP;
          else if (req_op == OP_SH || req_op == OP_SB)
            state_d = RMW_RD;
          else
            state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_ce   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        if (op_q == OP_SW) begin
          mem_we     = 1'b1;
          mem_wtData = wdata_q;
        end else begin
          rsp_data_d = load_ext(op_q, addr_q[1:0], mem_rdData);
        end
        state_d = RESP;
      end
      RMW_RD: begin
        mem_ce   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        old_d    = mem_rdData;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        mem_ce     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wtData = merge(op_q, addr_q[1:0], old_q, wdata_q);
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      old_q      <= 32'h0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      old_q      <= old_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store initiator that sits between the CPU memory stage and the word-only data memory.
- Accepts one load/store request at a time and drives the memory's ce/we/addr/wtData.
- Extracts and extends sub-word load data and returns one registered response per request.
- Because the memory writes whole words only, SH/SB are done as a read-modify-write over two memory cycles.

Parameters:
- MEM_BYTES, 4096, byte size of the attached data memory; used only for the range check under LSU_ERR_EN.

Ports:
- clk  in  1  clock; memory writes on the same posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready.
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.
- mem_ce  out  1  memory chip enable (1 = enable).
- mem_we  out  1  memory write enable (1 = write).
- mem_addr  out  32  word address, with bits [1:0] forced to 0.
- mem_wtData  out  32  word write data.
- mem_rdData  in  32  combinational read data from memory.

Behaviour:
- Reset (asynchronous): state = IDLE; req_ready = 1; rsp_valid = 0; rsp_data = 0; rsp_err = 0; mem_ce = mem_we = 0; mem_addr = mem_wtData = 0.
- Acceptance: in IDLE, req_valid && req_ready registers op, addr, wdata and the lane bits addr[1:0]. req_ready = 1 only in IDLE.
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- IDLE transitions on accept:
  - error -> RESP
  - SH/SB -> RMW_RD
  - all others -> ACCESS
- ACCESS:
  - mem_ce = 1; mem_we = 1 for SW, else 0.
  - Loads capture mem_rdData at the closing edge.
  - Next state RESP.
- RMW_RD: mem_ce = 1, mem_we = 0; captures the old word; next state RMW_WR.
- RMW_WR:
  - mem_ce = 1, mem_we = 1.
  - mem_wtData = old word with the selected byte/halfword lane replaced by req_wdata[7:0] or [15:0].
  - Next state RESP.
- RESP:
  - rsp_valid = 1; rsp_data/rsp_err are registered and stable.
  - Held until rsp_ready = 1; then IDLE.
  - rsp_ready is ignored in all other states.
- Memory outputs are decoded from state. In IDLE and RESP: mem_ce = 0, mem_we = 0, mem_wtData = 0.
- mem_addr = {addr[31:2], 2'b00} during ACCESS/RMW_*.
- Lanes are little-endian: addr[1:0] = 0 -> bits [7:0]; addr[1] = 1 -> halfword [31:16].
- Load extension:
  - LH/LB sign-extend.
  - LHU/LBU zero-extend.
  - LW passes the word through.
- Latency, counted from the accept edge E0:
  - LW/LH/LB/SW: rsp_valid rises after E1.
  - SH/SB: rsp_valid rises after E2.
  - Error: rsp_valid rises after E0.
  - With rsp_ready held at 1, IDLE is reached one edge after rsp_valid rises.
  - Back-to-back requests are therefore spaced by at least 3 cycles (4 for RMW).
- Reset mid-operation:
  - Returns to IDLE immediately and drops mem_ce at once.
  - If reset hits in RMW_RD, memory is unchanged.
  - A write already committed at an earlier edge stands.
- A new req_valid while busy is not accepted; it is held by the requester.

Optional Feature:
- Macro: LSU_ERR_EN.
- Defined:
  - Misaligned accesses are flagged: LW/SW with addr[1:0] != 0, or LH/LHU/SH with addr[0] = 1.
  - Accesses with addr >= MEM_BYTES are also flagged.
  - A flagged request makes no memory access: mem_ce stays 0, rsp_err = 1, rsp_data = 0.
- Undefined:
  - No error check; rsp_err tied 0.
  - Misaligned addresses are truncated: word ops use the aligned word; halfword ops use addr[1] only.
  - The address is not range-checked.

Test Plan:
- LW addr 0x10, mem word 0x8899AABB -> mem_ce = 1, we = 0 one cycle at mem_addr 0x10; rsp_data = 0x8899AABB, rsp_err = 0 two cycles after accept.
- LB addr 0x13 and LBU addr 0x13, word 0x8899AABB -> LB rsp_data = 0xFFFFFF88; LBU rsp_data = 0x00000088.
- Old word 0x11223344 at 0x20:
  - SB addr 0x21, wdata 0x000000EE -> RMW_RD then RMW_WR writes 0x1122EE44.
  - SH addr 0x22, wdata 0x0000BEEF -> word becomes 0xBEEFEE44; rsp_data = 0.
- SW addr 0x40, data 0xDEADBEEF; hold rsp_ready = 0 for 3 cycles -> rsp_valid held 3+ cycles and req_ready = 0 throughout; a following LW 0x40 returns 0xDEADBEEF.
- With LSU_ERR_EN: LW addr 0x42 and SW addr 0x1000 (MEM_BYTES = 4096) -> mem_ce never asserted, rsp_err = 1, rsp_data = 0, one cycle after accept. Without LSU_ERR_EN: LW addr 0x42 reads word 0x40.
- SB accepted, rst pulsed during RMW_RD -> mem_ce drops asynchronously, state IDLE, target word unchanged, rsp_valid = 0.
